// File: rtl/fetch_unit.sv
// Instruction fetch stage: loads the reset vector, then streams sequential words
// over a valid/ready memory port into a small FIFO feeding decode, with redirect/flush.
module fetch_unit #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0000,
    parameter int          DEPTH       = 4,
    parameter int          INSTR_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]  ALIGN     = ~XLEN'(3);
    localparam logic [XLEN-1:0]  PC_STEP   = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0]  VEC_ADDR  = XLEN'(VECTOR_ADDR);

    typedef enum logic {VEC, RUN} state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [XLEN-1:0]   buf_instr [DEPTH];
    logic [XLEN-1:0]   buf_pc    [DEPTH];

    logic transfer;
    logic push;
    logic pop;
    logic flush;

    // Request/address generation and next-state; reset gates every output low.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        mem_req_o  = 1'b0;
        mem_addr_o = pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            VEC: begin
                mem_req_o  = !reset;
                mem_addr_o = VEC_ADDR;
                if (mem_req_o && mem_ack_i) begin
                    pc_next    = data_i & ALIGN;
                    state_next = RUN;
                end
            end
            RUN: begin
                mem_req_o  = !reset && (count < FULL);
                mem_addr_o = pc;
                if (redirect_i) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc_i & ALIGN;
                end else if (mem_req_o && mem_ack_i) begin
                    push    = 1'b1;
                    pc_next = pc + PC_STEP;
                end
            end
            default: state_next = VEC;
        endcase
    end

    assign transfer      = mem_req_o && mem_ack_i;
    assign instr_valid_o = !reset && (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? buf_instr[rd_ptr] : '0;
    assign instr_pc_o    = instr_valid_o ? buf_pc[rd_ptr] : '0;
    assign pc_o          = pc;

    // Control state: flush takes priority over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= VEC;
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && transfer) begin
            buf_instr[wr_ptr] <= data_i;
            buf_pc[wr_ptr]    <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected {pc,instr} pairs are queued as fetches are
// issued and a monitor pops and compares them whenever decode accepts a word.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [31:0] pc_o;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
        .data_i(data_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_ready_i(instr_ready_i), .pc_o(pc_o)
    );

    always #5 clk = ~clk;

    // Memory model: address 0 holds the (misaligned) reset vector, others addr+0x13000000.
    assign data_i = (mem_addr_o == 32'h0) ? 32'h0000_1003 : mem_addr_o + 32'h1300_0000;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic ack, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        reset         = rst;
        mem_ack_i     = ack;
        instr_ready_i = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic expectInstr(input logic [31:0] pc, input logic [31:0] word);
        exp_q.push_back({pc, word});
    endtask

    // Monitor: compare every word decode accepts against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_pop: got pc %h instr %h expected nothing",
                         instr_pc_o, instr_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checkOutput("pop_pc", instr_pc_o, e[63:32]);
                checkOutput("pop_instr", instr_o, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; mem_ack_i = 1'b0; instr_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;

        // Reset held for two edges; outputs quiet.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_req", {31'b0, mem_req_o}, 0);
        checkOutput("rst_valid", {31'b0, instr_valid_o}, 0);
        checkOutput("rst_pc", pc_o, 0);
        checkOutput("rst_instr", instr_o, 0);
        checkOutput("rst_instr_pc", instr_pc_o, 0);

        // Vector fetch with ack delayed three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("vec_req_hold", {31'b0, mem_req_o}, 1);
            checkOutput("vec_addr_hold", mem_addr_o, 32'h0);
        end
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("vec_addr_ack", mem_addr_o, 32'h0);

        // Sequential fetch, decode always ready.
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("vec_loaded_pc", pc_o, 32'h1000);
        checkOutput("run_addr", mem_addr_o, 32'h1000);
        checkOutput("first_valid_early", {31'b0, instr_valid_o}, 0);
        expectInstr(32'h1000, 32'h1300_1000);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("first_valid", {31'b0, instr_valid_o}, 1);
        expectInstr(32'h1004, 32'h1300_1004);
        applyStimulus(0, 1, 1, 0, 0);
        expectInstr(32'h1008, 32'h1300_1008);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("seq_drained", {31'b0, instr_valid_o}, 0);
        checkOutput("seq_pc", pc_o, 32'h100C);

        // Backpressure: four transfers fill the buffer, then requests stop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("bp_req", {31'b0, mem_req_o}, 1);
        end
        expectInstr(32'h100C, 32'h1300_100C);
        expectInstr(32'h1010, 32'h1300_1010);
        expectInstr(32'h1014, 32'h1300_1014);
        expectInstr(32'h1018, 32'h1300_1018);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 0, 0, 0);
            checkOutput("bp_full_req", {31'b0, mem_req_o}, 0);
            checkOutput("bp_head_pc", instr_pc_o, 32'h100C);
            checkOutput("bp_pc_stall", pc_o, 32'h101C);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("bp_drained", {31'b0, instr_valid_o}, 0);

        // Redirect colliding with a transfer and a pop.
        applyStimulus(0, 1, 0, 0, 0);
        expectInstr(32'h101C, 32'h1300_101C);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 32'h2002);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("redir_valid", {31'b0, instr_valid_o}, 0);
        checkOutput("redir_addr", mem_addr_o, 32'h2000);
        checkOutput("redir_pc", pc_o, 32'h2000);

        // Wrap across the top of the address space.
        applyStimulus(0, 0, 1, 1, 32'hFFFF_FFF8);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("wrap_addr0", mem_addr_o, 32'hFFFF_FFF8);
        expectInstr(32'hFFFF_FFF8, 32'h12FF_FFF8);
        applyStimulus(0, 1, 1, 0, 0);
        expectInstr(32'hFFFF_FFFC, 32'h12FF_FFFC);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("wrap_addr", mem_addr_o, 32'h0);
        checkOutput("wrap_pc", pc_o, 32'h0);

        // Reset with three words buffered.
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0);
        checkOutput("pre_rst_valid", {31'b0, instr_valid_o}, 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("mid_rst_req", {31'b0, mem_req_o}, 0);
        checkOutput("mid_rst_valid", {31'b0, instr_valid_o}, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("post_rst_valid", {31'b0, instr_valid_o}, 0);
        checkOutput("post_rst_addr", mem_addr_o, 32'h0);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("revec_pc", pc_o, 32'h1000);
        checkOutput("revec_valid", {31'b0, instr_valid_o}, 0);

        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction fetch stage and successor to the single-register PC block. After reset it loads the reset vector from memory, then fetches sequential instruction words over a valid/ready memory port. Fetched words and their PCs go into a DEPTH-entry FIFO that feeds decode. It supports branch/exception redirect with a buffer flush, and backpressure from decode.

Parameters:
XLEN, 32, width of PC, address and instruction word.
VECTOR_ADDR, 32'h0000_0000, address from which the reset vector is read.
DEPTH, 4, instruction buffer entries; power of two, >= 2.
INSTR_BYTES, 4, PC increment per fetched word.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
mem_req_o  output  1  memory request valid.
mem_addr_o  output  XLEN  request address; word aligned.
mem_ack_i  input  1  memory ready; a transfer occurs when mem_req_o && mem_ack_i.
data_i  input  XLEN  read data; valid in the transfer cycle.
redirect_i  input  1  redirect request from execute.
redirect_pc_i  input  XLEN  redirect target.
instr_valid_o  output  1  buffer head valid.
instr_o  output  XLEN  head instruction word.
instr_pc_o  output  XLEN  PC of head instruction.
instr_ready_i  input  1  decode accepts head; pop when instr_valid_o && instr_ready_i.
pc_o  output  XLEN  address of the next word to be fetched.

Behaviour:
- Reset (reset=1 at a rising edge):
  - state<=VEC, pc<=0, FIFO pointers and count<=0.
  - Outputs during reset: mem_req_o=0, instr_valid_o=0, pc_o=0, instr_o and instr_pc_o=0.
- States:
  - VEC:
    - mem_req_o=1, mem_addr_o=VECTOR_ADDR.
    - On transfer: pc<=data_i with bits [1:0] forced to 0; go to RUN.
    - redirect_i is ignored.
  - RUN:
    - mem_req_o=1 only when count<DEPTH (registered count; a same-cycle pop does not count).
    - mem_addr_o=pc.
    - On transfer without redirect: push {pc,data_i}; pc<=pc+INSTR_BYTES.
- Handshake:
  - Transfer is combinational in the cycle both mem_req_o and mem_ack_i are high.
  - mem_req_o may deassert without a transfer; memory holds no outstanding state.
  - mem_ack_i while mem_req_o=0 has no effect.
- Latency:
  - A transfer in cycle N gives instr_valid_o=1 in cycle N+1 if the FIFO was empty.
  - Peak throughput is one word per cycle.
- FIFO:
  - Push and pop in the same cycle are legal at any count; count is unchanged.
  - Pop when empty is ignored.
  - Head outputs hold stable while instr_valid_o=1 and instr_ready_i=0.
- Redirect (RUN, redirect_i=1):
  - FIFO flushed (count<=0) and pc<=redirect_pc_i with bits [1:0] cleared.
  - Any memory transfer in that cycle is discarded: no push, no pc increment.
  - A pop in that cycle is still reported to decode; flush wins for state.
  - Next cycle: instr_valid_o=0, mem_addr_o=new pc.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Reset mid-operation discards the FIFO contents and any in-flight transfer, then re-enters VEC.
- pc_o always equals the pc register. mem_addr_o equals pc in RUN and VECTOR_ADDR in VEC.

Test Plan:
- Reset vector load: reset 2 cycles, memory returns 32'h0000_1000 for address 0 with ack delayed 3 cycles -> mem_addr_o=0 held stable with mem_req_o=1 until ack; then pc_o=32'h1000, mem_addr_o=32'h1000 the next cycle.
- Sequential fetch: ack every cycle, instr_ready_i=1 -> instr_pc_o sequence 1000,1004,1008; instr_o matches memory; first instr_valid_o one cycle after first transfer.
- Backpressure: instr_ready_i=0, DEPTH=4 -> exactly 4 transfers, then mem_req_o=0; head stays at PC 1000; after instr_ready_i=1 the order is preserved and there are no duplicates.
- Redirect collision: redirect_i=1 with redirect_pc_i=32'h2002 in the same cycle as a transfer of PC 100C -> 100C not pushed, instr_valid_o=0 next cycle, mem_addr_o=32'h2000.
- Wrap: redirect to 32'hFFFF_FFF8, ack twice -> instr_pc_o FFFF_FFF8, FFFF_FFFC, then mem_addr_o=0.
- Reset mid-run: assert reset with 3 entries buffered -> next cycle instr_valid_o=0, mem_req_o=0; after release mem_addr_o=VECTOR_ADDR.
